// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register: valid/ready handshake with a main entry (drives EX) and
// a one-deep skid entry that absorbs the one beat which slips past a registered in_ready.
module id_ex_skid_reg #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               regwrited,
   input  logic               memtoregd,
   input  logic               memwrited,
   input  logic               alusrcd,
   input  logic               regdstd,
   input  logic [3:0]         aluop,
   input  logic [WIDTH-1:0]   rd1d,
   input  logic [WIDTH-1:0]   rd2d,
   input  logic [WIDTH-1:0]   signimmd,
   input  logic [REGBITS-1:0] rsd,
   input  logic [REGBITS-1:0] rtd,
   input  logic [REGBITS-1:0] rdd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               regwritee,
   output logic               memtorege,
   output logic               memwritee,
   output logic               alusrce,
   output logic               regdste,
   output logic [3:0]         aluope,
   output logic [WIDTH-1:0]   rd1e,
   output logic [WIDTH-1:0]   rd2e,
   output logic [WIDTH-1:0]   signimme,
   output logic [REGBITS-1:0] rse,
   output logic [REGBITS-1:0] rte,
   output logic [REGBITS-1:0] rde
);

   localparam int PW = 9 + 3*WIDTH + 3*REGBITS;

   logic [PW-1:0] in_pkt;
   logic [PW-1:0] m_data_q, m_data_d;
   logic [PW-1:0] s_data_q, s_data_d;
   logic          m_valid_q, m_valid_d;
   logic          s_valid_q, s_valid_d;
   logic          in_ready_q;
   logic          accept, deliver;

   logic          m_regwrite, m_memtoreg, m_memwrite;
   logic [3:0]    m_aluop;

   assign in_pkt = {regwrited, memtoregd, memwrited, alusrcd, regdstd, aluop,
                    rd1d, rd2d, signimmd, rsd, rtd, rdd};

   assign accept  = in_valid & in_ready_q;
   assign deliver = m_valid_q & out_ready;

   always_comb begin
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (!m_valid_q) begin
         if (accept) begin
            m_data_d  = in_pkt;
            m_valid_d = 1'b1;
         end
      end else if (deliver) begin
         if (s_valid_q) begin
            // in_ready is low whenever S is full, so nothing new can arrive here
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
         end else if (accept) begin
            m_data_d  = in_pkt;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept) begin
         s_data_d  = in_pkt;
         s_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
         m_data_q   <= '0;
         s_data_q   <= '0;
      end else if (flush) begin
         // data registers keep their contents; only the valid bits are killed
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         m_valid_q  <= m_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= ~s_valid_d;
         m_data_q   <= m_data_d;
         s_data_q   <= s_data_d;
      end
   end

   assign {m_regwrite, m_memtoreg, m_memwrite, alusrce, regdste, m_aluop,
           rd1e, rd2e, signimme, rse, rte, rde} = m_data_q;

   // Side-effecting controls read as a bubble whenever M is empty
   assign regwritee = m_regwrite & m_valid_q;
   assign memtorege = m_memtoreg & m_valid_q;
   assign memwritee = m_memwrite & m_valid_q;
   assign aluope    = m_aluop & {4{m_valid_q}};

   assign out_valid = m_valid_q;
   assign in_ready  = in_ready_q;

endmodule
